// File: rtl/decex_pkg.sv
// Shared constants for the RV64I decode/execute stage: widths, opcodes,
// funct3/funct7 values and the 4-bit ALU control encoding.
package decex_pkg;

  localparam int XLEN    = 64;
  localparam int PC_STEP = 4;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_SD = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_LD_SD   = 3'b011;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;
  localparam logic [2:0] F3_BLT     = 3'b100;
  localparam logic [2:0] F3_BGE     = 3'b101;
  localparam logic [2:0] F3_BLTU    = 3'b110;
  localparam logic [2:0] F3_BGEU    = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  // RV64 immediate shifts use a 6-bit shamt, so only instr[31:26] carries the funct code
  localparam logic [5:0] F6_BASE = 6'b000000;
  localparam logic [5:0] F6_ALT  = 6'b010000;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_XOR  = 4'b1000,
    ALU_SLL  = 4'b1001,
    ALU_SRL  = 4'b1010,
    ALU_SRA  = 4'b1011,
    ALU_SLTU = 4'b1100
  } alu_ctrl_e;

endpackage

// File: rtl/decex_alu.sv
// Combinational 64-bit ALU. Shifts use the low 6 bits of operand B;
// set-less-than results are 0/1 zero-extended.
module decex_alu
  import decex_pkg::*;
(
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic [3:0]      i_ctrl,
  output logic [XLEN-1:0] o_result,
  output logic            o_zero
);

  logic [5:0] w_shamt;
  assign w_shamt = i_b[5:0];

  // Operation select
  always_comb begin
    o_result = '0;
    case (i_ctrl)
      ALU_AND:  o_result = i_a & i_b;
      ALU_OR:   o_result = i_a | i_b;
      ALU_ADD:  o_result = i_a + i_b;
      ALU_SUB:  o_result = i_a - i_b;
      ALU_SLT:  o_result = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      ALU_XOR:  o_result = i_a ^ i_b;
      ALU_SLL:  o_result = i_a << w_shamt;
      ALU_SRL:  o_result = i_a >> w_shamt;
      ALU_SRA:  o_result = $unsigned($signed(i_a) >>> w_shamt);
      ALU_SLTU: o_result = {{(XLEN-1){1'b0}}, (i_a < i_b)};
      default:  o_result = '0;
    endcase
  end

  assign o_zero = (o_result == '0);

endmodule

// File: rtl/decode_execute_stage.sv
// RV64I decode + operand select + execute stage. Register addresses are
// combinational; every execute result is registered once.
// Optional macro DECEX_BRANCH_EXT_EN adds blt/bge/bltu/bgeu decoding;
// without it those funct3 values flag inv_func.
module decode_execute_stage
  import decex_pkg::*;
(
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_in_valid,
  input  logic [31:0]     i_instruction,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  output logic [4:0]      o_write_addr,
  output logic            o_out_valid,
  output logic [XLEN-1:0] o_alu_result,
  output logic [XLEN-1:0] o_store_data,
  output logic [XLEN-1:0] o_next_pc,
  output logic            o_reg_write,
  output logic            o_mem_read,
  output logic            o_mem_to_reg,
  output logic            o_mem_write,
  output logic            o_branch_taken,
  output logic            o_inv_op,
  output logic            o_inv_func
);

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm;
  logic [3:0]      w_alu_ctrl;
  logic            w_use_imm, w_is_branch, w_cond;
  logic            w_reg_write, w_mem_read, w_mem_to_reg, w_mem_write;
  logic            w_inv_op, w_inv_func, w_illegal, w_taken;
  logic [XLEN-1:0] w_op_b, w_alu_out, w_result, w_next_pc;
  logic            w_zero;

  logic            r_out_valid, r_reg_write, r_mem_read, r_mem_to_reg, r_mem_write;
  logic            r_branch_taken, r_inv_op, r_inv_func;
  logic [XLEN-1:0] r_alu_result, r_store_data, r_next_pc;

  assign w_opcode     = i_instruction[6:0];
  assign w_funct3     = i_instruction[14:12];
  assign w_funct7     = i_instruction[31:25];
  assign o_rs1        = i_instruction[19:15];
  assign o_rs2        = i_instruction[24:20];
  assign o_write_addr = i_instruction[11:7];

  assign w_imm_i = {{(XLEN-12){i_instruction[31]}}, i_instruction[31:20]};
  assign w_imm_s = {{(XLEN-12){i_instruction[31]}}, i_instruction[31:25], i_instruction[11:7]};
  assign w_imm_b = {{(XLEN-13){i_instruction[31]}}, i_instruction[31], i_instruction[7],
                    i_instruction[30:25], i_instruction[11:8], 1'b0};

  // Main decode: ALU op, operand source, controls and legality flags
  always_comb begin
    w_alu_ctrl   = ALU_ADD;
    w_use_imm    = 1'b0;
    w_imm        = w_imm_i;
    w_is_branch  = 1'b0;
    w_reg_write  = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_to_reg = 1'b0;
    w_mem_write  = 1'b0;
    w_inv_op     = 1'b0;
    w_inv_func   = 1'b0;
    case (w_opcode)
      OP_R: begin
        w_reg_write = 1'b1;
        case (w_funct3)
          F3_ADD_SUB: begin
            if (w_funct7 == F7_BASE)     w_alu_ctrl = ALU_ADD;
            else if (w_funct7 == F7_ALT) w_alu_ctrl = ALU_SUB;
            else                         w_inv_func = 1'b1;
          end
          F3_SR: begin
            if (w_funct7 == F7_BASE)     w_alu_ctrl = ALU_SRL;
            else if (w_funct7 == F7_ALT) w_alu_ctrl = ALU_SRA;
            else                         w_inv_func = 1'b1;
          end
          default: begin
            case (w_funct3)
              F3_SLL:  w_alu_ctrl = ALU_SLL;
              F3_SLT:  w_alu_ctrl = ALU_SLT;
              F3_SLTU: w_alu_ctrl = ALU_SLTU;
              F3_XOR:  w_alu_ctrl = ALU_XOR;
              F3_OR:   w_alu_ctrl = ALU_OR;
              default: w_alu_ctrl = ALU_AND;
            endcase
            if (w_funct7 != F7_BASE) w_inv_func = 1'b1;
          end
        endcase
      end
      OP_I: begin
        w_reg_write = 1'b1;
        w_use_imm   = 1'b1;
        case (w_funct3)
          F3_ADD_SUB: w_alu_ctrl = ALU_ADD;
          F3_SLT:     w_alu_ctrl = ALU_SLT;
          F3_SLTU:    w_alu_ctrl = ALU_SLTU;
          F3_XOR:     w_alu_ctrl = ALU_XOR;
          F3_OR:      w_alu_ctrl = ALU_OR;
          F3_AND:     w_alu_ctrl = ALU_AND;
          F3_SLL: begin
            w_alu_ctrl = ALU_SLL;
            if (i_instruction[31:26] != F6_BASE) w_inv_func = 1'b1;
          end
          default: begin
            if (i_instruction[31:26] == F6_BASE)     w_alu_ctrl = ALU_SRL;
            else if (i_instruction[31:26] == F6_ALT) w_alu_ctrl = ALU_SRA;
            else                                     w_inv_func = 1'b1;
          end
        endcase
      end
      OP_LD: begin
        w_use_imm = 1'b1;
        if (w_funct3 == F3_LD_SD) begin
          w_reg_write  = 1'b1;
          w_mem_read   = 1'b1;
          w_mem_to_reg = 1'b1;
        end else begin
          w_inv_func = 1'b1;
        end
      end
      OP_SD: begin
        w_use_imm = 1'b1;
        w_imm     = w_imm_s;
        if (w_funct3 == F3_LD_SD) w_mem_write = 1'b1;
        else                      w_inv_func  = 1'b1;
      end
      OP_BR: begin
        w_alu_ctrl  = ALU_SUB;
        w_is_branch = 1'b1;
        case (w_funct3)
          F3_BEQ, F3_BNE: w_inv_func = 1'b0;
`ifdef DECEX_BRANCH_EXT_EN
          F3_BLT, F3_BGE, F3_BLTU, F3_BGEU: w_inv_func = 1'b0;
`endif
          default: w_inv_func = 1'b1;
        endcase
      end
      default: w_inv_op = 1'b1;
    endcase
    // An illegal instruction must not disturb architectural state
    if (w_inv_op || w_inv_func) begin
      w_reg_write  = 1'b0;
      w_mem_read   = 1'b0;
      w_mem_to_reg = 1'b0;
      w_mem_write  = 1'b0;
      w_is_branch  = 1'b0;
    end
  end

  assign w_illegal = w_inv_op | w_inv_func;
  assign w_op_b    = w_use_imm ? w_imm : i_rs2_data;

  decex_alu u_alu (
    .i_a      (i_rs1_data),
    .i_b      (w_op_b),
    .i_ctrl   (w_alu_ctrl),
    .o_result (w_alu_out),
    .o_zero   (w_zero)
  );

  // Branch condition from the rs1-rs2 difference and direct compares
  always_comb begin
    w_cond = 1'b0;
    case (w_funct3)
      F3_BEQ:  w_cond = w_zero;
      F3_BNE:  w_cond = ~w_zero;
`ifdef DECEX_BRANCH_EXT_EN
      F3_BLT:  w_cond = ($signed(i_rs1_data) <  $signed(i_rs2_data));
      F3_BGE:  w_cond = ($signed(i_rs1_data) >= $signed(i_rs2_data));
      F3_BLTU: w_cond = (i_rs1_data <  i_rs2_data);
      F3_BGEU: w_cond = (i_rs1_data >= i_rs2_data);
`endif
      default: w_cond = 1'b0;
    endcase
  end

  assign w_taken   = w_is_branch & w_cond;
  assign w_next_pc = w_taken ? (i_pc + w_imm_b) : (i_pc + XLEN'(PC_STEP));
  assign w_result  = w_illegal ? '0 : w_alu_out;

  // Output register; controls are qualified by in_valid, datapath always captured
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_out_valid    <= 1'b0;
      r_alu_result   <= '0;
      r_store_data   <= '0;
      r_next_pc      <= '0;
      r_reg_write    <= 1'b0;
      r_mem_read     <= 1'b0;
      r_mem_to_reg   <= 1'b0;
      r_mem_write    <= 1'b0;
      r_branch_taken <= 1'b0;
      r_inv_op       <= 1'b0;
      r_inv_func     <= 1'b0;
    end else begin
      r_out_valid    <= i_in_valid;
      r_alu_result   <= w_result;
      r_store_data   <= i_rs2_data;
      r_next_pc      <= w_next_pc;
      r_reg_write    <= i_in_valid & w_reg_write;
      r_mem_read     <= i_in_valid & w_mem_read;
      r_mem_to_reg   <= i_in_valid & w_mem_to_reg;
      r_mem_write    <= i_in_valid & w_mem_write;
      r_branch_taken <= i_in_valid & w_taken;
      r_inv_op       <= i_in_valid & w_inv_op;
      r_inv_func     <= i_in_valid & w_inv_func;
    end
  end

  assign o_out_valid    = r_out_valid;
  assign o_alu_result   = r_alu_result;
  assign o_store_data   = r_store_data;
  assign o_next_pc      = r_next_pc;
  assign o_reg_write    = r_reg_write;
  assign o_mem_read     = r_mem_read;
  assign o_mem_to_reg   = r_mem_to_reg;
  assign o_mem_write    = r_mem_write;
  assign o_branch_taken = r_branch_taken;
  assign o_inv_op       = r_inv_op;
  assign o_inv_func     = r_inv_func;

endmodule

// File: tb/tb_decode_execute_stage.sv
// Bench for decode_execute_stage: directed vector table, hand-written reset
// sequence, and randomized instructions checked against a mnemonic-level model.
module tb_decode_execute_stage;

  logic        i_clock, i_reset, i_in_valid;
  logic [31:0] i_instruction;
  logic [63:0] i_pc, i_rs1_data, i_rs2_data;
  logic [4:0]  o_rs1, o_rs2, o_write_addr;
  logic        o_out_valid, o_reg_write, o_mem_read, o_mem_to_reg, o_mem_write;
  logic        o_branch_taken, o_inv_op, o_inv_func;
  logic [63:0] o_alu_result, o_store_data, o_next_pc;

  int tests_run = 0;
  int tests_failed = 0;

  decode_execute_stage dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_in_valid(i_in_valid),
    .i_instruction(i_instruction), .i_pc(i_pc),
    .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data),
    .o_rs1(o_rs1), .o_rs2(o_rs2), .o_write_addr(o_write_addr),
    .o_out_valid(o_out_valid), .o_alu_result(o_alu_result),
    .o_store_data(o_store_data), .o_next_pc(o_next_pc),
    .o_reg_write(o_reg_write), .o_mem_read(o_mem_read), .o_mem_to_reg(o_mem_to_reg),
    .o_mem_write(o_mem_write), .o_branch_taken(o_branch_taken),
    .o_inv_op(o_inv_op), .o_inv_func(o_inv_func)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  // flags order: {reg_write, mem_read, mem_to_reg, mem_write, branch_taken, inv_op, inv_func}
  typedef struct {
    string       name;
    logic        v;
    logic [31:0] ins;
    logic [63:0] pc, a, b, alu, npc;
    logic [6:0]  fl;
  } vec_t;

  typedef struct {
    logic [63:0] alu, npc;
    logic [6:0]  fl;
  } exp_t;

  function automatic logic [31:0] r_enc(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_enc(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] s_enc(input logic [11:0] imm, input logic [4:0] rs2, rs1,
                                        input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] b_enc(input logic [12:0] imm, input logic [4:0] rs2, rs1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  // Reference model: interprets the instruction as a mnemonic and evaluates it arithmetically
  function automatic exp_t model(input logic v, input logic [31:0] ins,
                                 input logic [63:0] pc, a, b);
    exp_t e;
    logic [63:0] ii, si, bi, res;
    logic rw, mr, mw, bt, bad_op, bad_fn;
    ii = {{52{ins[31]}}, ins[31:20]};
    si = {{52{ins[31]}}, ins[31:25], ins[11:7]};
    bi = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    res = 0; rw = 0; mr = 0; mw = 0; bt = 0; bad_op = 0; bad_fn = 0;
    case (ins[6:0])
      7'h33: begin
        rw = 1;
        case ({ins[31:25], ins[14:12]})
          {7'h00, 3'd0}: res = a + b;
          {7'h20, 3'd0}: res = a - b;
          {7'h00, 3'd1}: res = a << b[5:0];
          {7'h00, 3'd2}: res = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
          {7'h00, 3'd3}: res = (a < b) ? 64'd1 : 64'd0;
          {7'h00, 3'd4}: res = a ^ b;
          {7'h00, 3'd5}: res = a >> b[5:0];
          {7'h20, 3'd5}: res = $unsigned($signed(a) >>> b[5:0]);
          {7'h00, 3'd6}: res = a | b;
          {7'h00, 3'd7}: res = a & b;
          default: bad_fn = 1;
        endcase
      end
      7'h13: begin
        rw = 1;
        case (ins[14:12])
          3'd0: res = a + ii;
          3'd2: res = ($signed(a) < $signed(ii)) ? 64'd1 : 64'd0;
          3'd3: res = (a < ii) ? 64'd1 : 64'd0;
          3'd4: res = a ^ ii;
          3'd6: res = a | ii;
          3'd7: res = a & ii;
          3'd1: if (ins[31:26] == 6'h00) res = a << ins[25:20]; else bad_fn = 1;
          default: begin
            if (ins[31:26] == 6'h00)      res = a >> ins[25:20];
            else if (ins[31:26] == 6'h10) res = $unsigned($signed(a) >>> ins[25:20]);
            else bad_fn = 1;
          end
        endcase
      end
      7'h03: if (ins[14:12] == 3'd3) begin res = a + ii; rw = 1; mr = 1; end else bad_fn = 1;
      7'h23: if (ins[14:12] == 3'd3) begin res = a + si; mw = 1; end else bad_fn = 1;
      7'h63: begin
        res = a - b;
        case (ins[14:12])
          3'd0: bt = (a == b);
          3'd1: bt = (a != b);
`ifdef DECEX_BRANCH_EXT_EN
          3'd4: bt = ($signed(a) < $signed(b));
          3'd5: bt = ($signed(a) >= $signed(b));
          3'd6: bt = (a < b);
          3'd7: bt = (a >= b);
`endif
          default: bad_fn = 1;
        endcase
      end
      default: bad_op = 1;
    endcase
    if (bad_op || bad_fn) begin
      res = 0; rw = 0; mr = 0; mw = 0; bt = 0;
    end
    e.alu = res;
    e.npc = bt ? pc + bi : pc + 64'd4;
    e.fl  = {rw, mr, mr, mw, bt, bad_op, bad_fn};
    if (!v) e.fl = 7'b0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string name);
    chk({name, ".valid"}, {63'd0, o_out_valid}, 64'd0);
    chk({name, ".alu"}, o_alu_result, 64'd0);
    chk({name, ".npc"}, o_next_pc, 64'd0);
    chk({name, ".store"}, o_store_data, 64'd0);
    chk({name, ".flags"}, {57'd0, o_reg_write, o_mem_read, o_mem_to_reg, o_mem_write,
                           o_branch_taken, o_inv_op, o_inv_func}, 64'd0);
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [63:0] pc, a, b);
    i_in_valid = v; i_instruction = ins; i_pc = pc; i_rs1_data = a; i_rs2_data = b;
  endtask

  task automatic apply(input string name, input logic v, input logic [31:0] ins,
                       input logic [63:0] pc, a, b, alu, npc, input logic [6:0] fl);
    @(negedge i_clock);
    drive(v, ins, pc, a, b);
    #1;
    chk({name, ".addr"}, {49'd0, o_rs1, o_rs2, o_write_addr},
        {49'd0, ins[19:15], ins[24:20], ins[11:7]});
    @(posedge i_clock);
    #1;
    chk({name, ".valid"}, {63'd0, o_out_valid}, {63'd0, v});
    chk({name, ".alu"}, o_alu_result, alu);
    chk({name, ".npc"}, o_next_pc, npc);
    chk({name, ".store"}, o_store_data, b);
    chk({name, ".flags"}, {57'd0, o_reg_write, o_mem_read, o_mem_to_reg, o_mem_write,
                           o_branch_taken, o_inv_op, o_inv_func}, {57'd0, fl});
  endtask

  vec_t vecs[$];

  initial begin
    vec_t t;
    exp_t e;
    logic [31:0] ins;
    logic [63:0] pc, a, b;
    logic v;
    int k;

    vecs.push_back('{"add", 1, r_enc(7'h00, 11, 10, 0, 3), 64'h0, 64'd10, 64'd11,
                     64'd21, 64'h4, 7'b1000000});
    vecs.push_back('{"addi_m1", 1, i_enc(12'hFFF, 0, 0, 1, 7'h13), 64'h10, 64'd0, 64'd9,
                     64'hFFFF_FFFF_FFFF_FFFF, 64'h14, 7'b1000000});
    vecs.push_back('{"sub", 1, r_enc(7'h20, 2, 1, 0, 3), 64'h20, 64'd5, 64'd13,
                     64'hFFFF_FFFF_FFFF_FFF8, 64'h24, 7'b1000000});
    vecs.push_back('{"ld", 1, i_enc(12'd8, 5, 3, 4, 7'h03), 64'h30, 64'd5, 64'h77,
                     64'd13, 64'h34, 7'b1110000});
    vecs.push_back('{"sd", 1, s_enc(12'd16, 6, 5, 3), 64'h40, 64'd5, 64'hDEAD,
                     64'd21, 64'h44, 7'b0001000});
    vecs.push_back('{"beq_taken", 1, b_enc(13'h1FF8, 2, 1, 0), 64'h100, 64'd7, 64'd7,
                     64'd0, 64'hF8, 7'b0000100});
    vecs.push_back('{"bne_not", 1, b_enc(13'h1FF8, 2, 1, 1), 64'h100, 64'd7, 64'd7,
                     64'd0, 64'h104, 7'b0000000});
    vecs.push_back('{"inv_op", 1, 32'h0000_007F, 64'h200, 64'd3, 64'd4,
                     64'd0, 64'h204, 7'b0000010});
    vecs.push_back('{"inv_func_r", 1, r_enc(7'h20, 2, 1, 7, 3), 64'h208, 64'd3, 64'd4,
                     64'd0, 64'h20C, 7'b0000001});
    vecs.push_back('{"pc_wrap", 1, r_enc(7'h00, 2, 1, 0, 3), 64'hFFFF_FFFF_FFFF_FFFC,
                     64'd1, 64'd2, 64'd3, 64'h0, 7'b1000000});
    vecs.push_back('{"not_valid", 0, r_enc(7'h00, 11, 10, 0, 3), 64'h0, 64'd10, 64'd11,
                     64'd21, 64'h4, 7'b0000000});
    vecs.push_back('{"srai", 1, i_enc({6'b010000, 6'd4}, 1, 5, 2, 7'h13), 64'h50,
                     64'hFFFF_FFFF_FFFF_FFF0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h54,
                     7'b1000000});
    vecs.push_back('{"slli_bad", 1, i_enc({6'b000001, 6'd4}, 1, 1, 2, 7'h13), 64'h60,
                     64'd1, 64'd0, 64'd0, 64'h64, 7'b0000001});
    vecs.push_back('{"x0_dest", 1, i_enc(12'd5, 1, 0, 0, 7'h13), 64'h70, 64'd2, 64'd0,
                     64'd7, 64'h74, 7'b1000000});
`ifdef DECEX_BRANCH_EXT_EN
    vecs.push_back('{"blt_taken", 1, b_enc(13'd16, 2, 1, 4), 64'h300, 64'd1, 64'd2,
                     64'hFFFF_FFFF_FFFF_FFFF, 64'h310, 7'b0000100});
`else
    vecs.push_back('{"blt_illegal", 1, b_enc(13'd16, 2, 1, 4), 64'h300, 64'd1, 64'd2,
                     64'd0, 64'h304, 7'b0000001});
`endif

    i_reset = 1'b1;
    drive(0, 32'h0, 64'h0, 64'h0, 64'h0);
    #2;
    chk_zero("reset");
    @(negedge i_clock);
    i_reset = 1'b0;

    foreach (vecs[i]) begin
      t = vecs[i];
      apply(t.name, t.v, t.ins, t.pc, t.a, t.b, t.alu, t.npc, t.fl);
    end

    // Reset asserted between edges clears outputs at once; operation resumes after release
    apply("pre_rst", 1, r_enc(7'h00, 11, 10, 0, 3), 64'h0, 64'd10, 64'd11,
          64'd21, 64'h4, 7'b1000000);
    @(negedge i_clock);
    drive(1, r_enc(7'h00, 2, 1, 4, 3), 64'h400, 64'hF0, 64'h0F);
    #1;
    i_reset = 1'b1;
    #1;
    chk_zero("mid_rst");
    @(posedge i_clock);
    #1;
    chk_zero("held_rst");
    @(negedge i_clock);
    i_reset = 1'b0;
    @(posedge i_clock);
    #1;
    chk("post_rst.alu", o_alu_result, 64'hFF);
    chk("post_rst.npc", o_next_pc, 64'h404);
    chk("post_rst.valid", {63'd0, o_out_valid}, 64'd1);

    for (int n = 0; n < 400; n++) begin
      k = $urandom_range(0, 9);
      a = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 70)) : {$urandom, $urandom};
      b = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 70)) : {$urandom, $urandom};
      pc = {$urandom, $urandom} & ~64'h3;
      v = ($urandom_range(0, 7) != 0);
      ins = $urandom;
      case (k)
        0, 1, 9: begin
          ins[6:0] = 7'h33;
          case ($urandom_range(0, 7))
            6: ins[31:25] = 7'h20;
            7: ins[31:25] = 7'($urandom);
            default: ins[31:25] = 7'h00;
          endcase
          if (k == 9) v = 0;
        end
        2, 3: begin
          ins[6:0] = 7'h13;
          if (ins[13:12] == 2'b01) begin
            case ($urandom_range(0, 3))
              0, 1: ins[31:26] = 6'h00;
              2: ins[31:26] = 6'h10;
              default: ins[31:26] = 6'($urandom);
            endcase
          end
        end
        4: begin
          ins[6:0] = 7'h03;
          if ($urandom_range(0, 4) != 0) ins[14:12] = 3'd3;
        end
        5: begin
          ins[6:0] = 7'h23;
          if ($urandom_range(0, 4) != 0) ins[14:12] = 3'd3;
        end
        6, 7: begin
          ins[6:0] = 7'h63;
          if ($urandom_range(0, 2) == 0) b = a;
        end
        default: ;
      endcase
      e = model(v, ins, pc, a, b);
      apply($sformatf("rand%0d", n), v, ins, pc, a, b, e.alu, e.npc, e.fl);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
